// File: rtl/axi_noc_traffic_gen_if.sv
// AXI4 bus bundle between the NoC traffic generator (master) and the fabric (slave).
interface axi_noc_traffic_gen_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned ID_W   = 2
);
  logic                awvalid, awready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [ID_W-1:0]     awid;
  logic [3:0]          awcache, awqos, awregion;
  logic [2:0]          awprot;
  logic                awlock;
  logic [17:0]         awuser;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic                bvalid, bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;

  logic                arvalid, arready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_W-1:0]     arid;
  logic [3:0]          arcache, arqos, arregion;
  logic [2:0]          arprot;
  logic                arlock;
  logic [17:0]         aruser;

  logic                rvalid, rready, rlast;
  logic [DATA_W-1:0]   rdata;
  logic [ID_W-1:0]     rid;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awid,
           awcache, awprot, awqos, awregion, awlock, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst, arid,
           arcache, arprot, arqos, arregion, arlock, aruser,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
           awcache, awprot, awqos, awregion, awlock, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
           arcache, arprot, arqos, arregion, arlock, aruser,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_noc_traffic_gen.sv
// AXI4 master traffic generator/checker: writes N_TRANS INCR bursts of a
// counting pattern from BASE_ADDR, reads them back and counts bad beats.
module axi_noc_traffic_gen #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned TXN_ID    = 0,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned N_TRANS   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0] SEED      = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [1:0]  out,
  output logic [15:0] err_cnt,
  axi_noc_traffic_gen_if.master axi
);

  localparam logic [2:0]        SIZE        = 3'($clog2(DATA_W/8));
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W/8));
  localparam logic [8:0]        LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [15:0]       LAST_TRANS  = 16'(N_TRANS - 1);
  localparam logic [31:0]       BURST_INC   = 32'(BURST_LEN);
  localparam logic [ID_W-1:0]   ID          = ID_W'(TXN_ID);

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_DONE} state_t;

  state_t            state_q;
  logic              awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [15:0]       trans_q;
  logic [8:0]        beat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       pat_q;   // pattern word of the current beat
  logic [31:0]       bpat_q;  // pattern word of beat 0 of the current burst
  logic [1:0]        out_q;
  logic [15:0]       err_cnt_q;

  logic [DATA_W-1:0] exp_data_d;
  logic              b_err_d, r_err_d, r_end_d;
  logic [15:0]       err_inc_d;

  // Response checks and saturating error increment for the current handshake
  always_comb begin
    exp_data_d = DATA_W'(pat_q);
    b_err_d    = (axi.bresp != 2'b00) || (axi.bid != ID);
    r_err_d    = (axi.rdata != exp_data_d) || (axi.rresp != 2'b00) ||
                 (axi.rid != ID) || (axi.rlast != (beat_q == LAST_BEAT));
    r_end_d    = axi.rlast || (beat_q == LAST_BEAT);
    err_inc_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  end

  // Sequencer: write phase, read/check phase, registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      trans_q   <= '0;
      beat_q    <= '0;
      addr_q    <= BASE_ADDR;
      pat_q     <= SEED;
      bpat_q    <= SEED;
      out_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_WA;
            awvalid_q <= 1'b1;
            out_q     <= '0;
            err_cnt_q <= '0;
            trans_q   <= '0;
            addr_q    <= BASE_ADDR;
            pat_q     <= SEED;
            bpat_q    <= SEED;
          end
        end
        S_WA: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (LAST_BEAT == 9'd0);
            beat_q    <= '0;
            state_q   <= S_WD;
          end
        end
        S_WD: begin
          if (axi.wready) begin
            pat_q   <= pat_q + 32'd1;
            beat_q  <= beat_q + 9'd1;
            wlast_q <= ((beat_q + 9'd1) == LAST_BEAT);
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            if (b_err_d) begin
              err_cnt_q <= err_inc_d;
              out_q[1]  <= 1'b1;
            end
            if (trans_q == LAST_TRANS) begin
              trans_q   <= '0;
              addr_q    <= BASE_ADDR;
              pat_q     <= SEED;
              bpat_q    <= SEED;
              arvalid_q <= 1'b1;
              state_q   <= S_RA;
            end else begin
              trans_q   <= trans_q + 16'd1;
              addr_q    <= addr_q + BURST_BYTES;
              pat_q     <= bpat_q + BURST_INC;
              bpat_q    <= bpat_q + BURST_INC;
              awvalid_q <= 1'b1;
              state_q   <= S_WA;
            end
          end
        end
        S_RA: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          if (axi.rvalid) begin
            if (r_err_d) begin
              err_cnt_q <= err_inc_d;
              out_q[1]  <= 1'b1;
            end
            pat_q  <= pat_q + 32'd1;
            beat_q <= beat_q + 9'd1;
            // Burst ends on rlast or after BURST_LEN beats, whichever first;
            // next burst's pattern restarts from bpat_q so an early rlast
            // does not shift the following bursts.
            if (r_end_d) begin
              rready_q <= 1'b0;
              if (trans_q == LAST_TRANS) begin
                out_q[0] <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                trans_q   <= trans_q + 16'd1;
                addr_q    <= addr_q + BURST_BYTES;
                pat_q     <= bpat_q + BURST_INC;
                bpat_q    <= bpat_q + BURST_INC;
                arvalid_q <= 1'b1;
                state_q   <= S_RA;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign axi.awvalid  = awvalid_q;
  assign axi.awaddr   = addr_q;
  assign axi.awlen    = 8'(BURST_LEN - 1);
  assign axi.awsize   = SIZE;
  assign axi.awburst  = 2'b01;
  assign axi.awid     = ID;
  assign axi.awcache  = 4'b0011;
  assign axi.awprot   = '0;
  assign axi.awqos    = '0;
  assign axi.awregion = '0;
  assign axi.awlock   = 1'b0;
  assign axi.awuser   = '0;

  assign axi.wvalid   = wvalid_q;
  assign axi.wdata    = exp_data_d;
  assign axi.wstrb    = '1;
  assign axi.wlast    = wlast_q;

  assign axi.bready   = bready_q;

  assign axi.arvalid  = arvalid_q;
  assign axi.araddr   = addr_q;
  assign axi.arlen    = 8'(BURST_LEN - 1);
  assign axi.arsize   = SIZE;
  assign axi.arburst  = 2'b01;
  assign axi.arid     = ID;
  assign axi.arcache  = 4'b0011;
  assign axi.arprot   = '0;
  assign axi.arqos    = '0;
  assign axi.arregion = '0;
  assign axi.arlock   = 1'b0;
  assign axi.aruser   = '0;

  assign axi.rready   = rready_q;

  assign out          = out_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_axi_noc_traffic_gen.sv
// Directed bench for axi_noc_traffic_gen: default 64-bit/16x8 instance with a
// memory model, plus a 128-bit single-beat instance.
module tb_axi_noc_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [1:0]  out0, out1;
  logic [15:0] err0, err1;

  axi_noc_traffic_gen_if if0 ();
  axi_noc_traffic_gen_if #(.DATA_W(128)) if1 ();

  axi_noc_traffic_gen dut0 (
    .clk(clk), .rst(rst), .start(start0), .out(out0), .err_cnt(err0), .axi(if0)
  );

  axi_noc_traffic_gen #(.DATA_W(128), .BURST_LEN(1), .N_TRANS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .out(out1), .err_cnt(err1), .axi(if1)
  );

  int checks = 0;
  int errors = 0;

  // Slave-model knobs
  bit bp        = 1'b0;
  int corrupt_g = -1;
  int rresp_g   = -1;
  int bresp_bst = -1;
  bit drop1     = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- dut0 memory slave ----------------
  logic [63:0] mem0 [0:127];
  logic [63:0] w_addr, b_addr, r_addr;
  bit          b_pend;
  int          r_rem, g;

  // Memory-backed AXI slave with optional random backpressure and fault injection
  always @(posedge clk) begin
    if (rst) begin
      if0.awready <= 1'b0; if0.wready <= 1'b0; if0.arready <= 1'b0;
      if0.bvalid  <= 1'b0; if0.rvalid <= 1'b0;
      b_pend = 1'b0; r_rem = 0;
    end else begin
      if0.awready <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if0.wready  <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if0.arready <= bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (if0.awvalid && if0.awready) begin w_addr = if0.awaddr; b_addr = if0.awaddr; end
      if (if0.wvalid && if0.wready) begin
        mem0[w_addr[9:3]] = if0.wdata;
        w_addr += 64'd8;
        if (if0.wlast) b_pend = 1'b1;
      end
      if (if0.bvalid && if0.bready) if0.bvalid <= 1'b0;
      else if (!if0.bvalid && b_pend && (!bp || $urandom_range(0, 1) == 1)) begin
        if0.bvalid <= 1'b1;
        if0.bid    <= '0;
        if0.bresp  <= (int'(b_addr >> 7) == bresp_bst) ? 2'b10 : 2'b00;
        b_pend = 1'b0;
      end
      if (if0.arvalid && if0.arready) begin r_addr = if0.araddr; r_rem = int'(if0.arlen) + 1; end
      if (if0.rvalid && if0.rready) begin r_addr += 64'd8; r_rem--; end
      if (!(if0.rvalid && !if0.rready)) begin
        if (r_rem > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
          g = int'(r_addr >> 3);
          if0.rvalid <= 1'b1;
          if0.rdata  <= mem0[r_addr[9:3]] ^ ((g == corrupt_g) ? 64'h1 : 64'h0);
          if0.rresp  <= (g == rresp_g) ? 2'b11 : 2'b00;
          if0.rid    <= '0;
          if0.rlast  <= (r_rem == 1);
        end else begin
          if0.rvalid <= 1'b0;
        end
      end
    end
  end

  // ---------------- dut0 monitor ----------------
  logic [63:0] aw_log [$];
  logic [7:0]  awlen_log [$];
  logic [63:0] w_log [$];
  bit          wlast_log [$];
  int          stab_err = 0, ovl_err = 0;
  bit          aw_st, w_st, ar_st, w_l;
  logic [63:0] aw_a, ar_a, w_d;

  // Logs handshakes, flags payload changes while stalled and AW/W overlap
  always @(posedge clk) begin
    if (aw_st && (!if0.awvalid || if0.awaddr !== aw_a)) stab_err++;
    if (w_st && (!if0.wvalid || if0.wdata !== w_d || if0.wlast !== w_l)) stab_err++;
    if (ar_st && (!if0.arvalid || if0.araddr !== ar_a)) stab_err++;
    if (!rst && if0.awvalid && if0.wvalid) ovl_err++;
    if (!rst && if0.awvalid && if0.awready) begin aw_log.push_back(if0.awaddr); awlen_log.push_back(if0.awlen); end
    if (!rst && if0.wvalid && if0.wready) begin w_log.push_back(if0.wdata); wlast_log.push_back(if0.wlast); end
    aw_st = !rst && if0.awvalid && !if0.awready; aw_a = if0.awaddr;
    w_st  = !rst && if0.wvalid && !if0.wready;   w_d = if0.wdata; w_l = if0.wlast;
    ar_st = !rst && if0.arvalid && !if0.arready; ar_a = if0.araddr;
  end

  // ---------------- dut1 single-beat slave ----------------
  logic [127:0] mem1;
  int           aw1_n = 0, w1_n = 0, w1_last = 0;
  logic [2:0]   awsize1;

  // Always-ready slave holding the one written beat
  always @(posedge clk) begin
    if (rst) begin
      if1.bvalid <= 1'b0; if1.rvalid <= 1'b0;
    end else begin
      if (if1.awvalid && if1.awready) begin aw1_n++; awsize1 = if1.awsize; end
      if (if1.wvalid && if1.wready) begin w1_n++; mem1 = if1.wdata; if (if1.wlast) w1_last++; end
      if (if1.bvalid && if1.bready) if1.bvalid <= 1'b0;
      else if (if1.wvalid && if1.wready && if1.wlast) begin
        if1.bvalid <= 1'b1; if1.bresp <= 2'b00; if1.bid <= '0;
      end
      if (if1.rvalid && if1.rready) if1.rvalid <= 1'b0;
      else if (if1.arvalid && if1.arready) begin
        if1.rvalid <= 1'b1; if1.rdata <= mem1; if1.rresp <= 2'b00;
        if1.rid <= '0; if1.rlast <= !drop1;
      end
    end
  end

  task automatic pulse0();
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
  endtask

  task automatic wait0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (out0[0]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run1(output bit ok);
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out1[0]) begin ok = 1'b1; break; end
    end
  endtask

  int aw_b, w_b, n0, n1, n2;
  bit ok;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    if1.awready = 1'b1; if1.wready = 1'b1; if1.arready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state and constant sideband
    chk("rst_out0", 64'(out0), 64'h0);
    chk("rst_err0", 64'(err0), 64'h0);
    chk("rst_awvalid", 64'(if0.awvalid), 64'h0);
    chk("rst_wvalid", 64'(if0.wvalid), 64'h0);
    chk("rst_bready", 64'(if0.bready), 64'h0);
    chk("rst_arvalid", 64'(if0.arvalid), 64'h0);
    chk("rst_rready", 64'(if0.rready), 64'h0);
    chk("rst_out1", 64'(out1), 64'h0);
    chk("awsize0", 64'(if0.awsize), 64'h3);
    chk("arsize0", 64'(if0.arsize), 64'h3);
    chk("awburst0", 64'(if0.awburst), 64'h1);
    chk("awcache0", 64'(if0.awcache), 64'h3);
    chk("arlen0", 64'(if0.arlen), 64'd15);
    chk("wstrb0", 64'(if0.wstrb), 64'hFF);
    chk("awsize1", 64'(if1.awsize), 64'h4);
    chk("wstrb1", 64'(if1.wstrb), 64'hFFFF);
    @(negedge clk) rst = 1'b0;

    // Pass 1: always-ready memory
    aw_b = aw_log.size(); w_b = w_log.size();
    pulse0(); wait0(ok);
    chk("p1_done", 64'(ok), 64'h1);
    chk("p1_out", 64'(out0), 64'h1);
    chk("p1_err", 64'(err0), 64'h0);
    chk("p1_aw_n", 64'(aw_log.size() - aw_b), 64'd8);
    chk("p1_w_n", 64'(w_log.size() - w_b), 64'd128);
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("p1_awaddr%0d", t), aw_log[aw_b + t], 64'(t * 128));
      chk($sformatf("p1_awlen%0d", t), 64'(awlen_log[aw_b + t]), 64'd15);
    end
    for (int i = 0; i < 128; i++) begin
      chk($sformatf("p1_wdata%0d", i), w_log[w_b + i], 64'h1000_0000 + 64'(i));
      chk($sformatf("p1_wlast%0d", i), 64'(wlast_log[w_b + i]), 64'((i % 16) == 15));
    end

    // Pass 2: random backpressure on every channel
    bp = 1'b1;
    w_b = w_log.size();
    pulse0(); wait0(ok);
    chk("p2_done", 64'(ok), 64'h1);
    chk("p2_out", 64'(out0), 64'h1);
    chk("p2_err", 64'(err0), 64'h0);
    chk("p2_stable", 64'(stab_err), 64'h0);
    chk("p2_no_aw_w_overlap", 64'(ovl_err), 64'h0);
    chk("p2_w_n", 64'(w_log.size() - w_b), 64'd128);
    chk("p2_wdata127", w_log[w_b + 127], 64'h1000_007F);
    bp = 1'b0;

    // Pass 3: corrupted read data on global beat 37, then restart clears status
    corrupt_g = 37;
    pulse0(); wait0(ok);
    chk("p3_done", 64'(ok), 64'h1);
    chk("p3_out", 64'(out0), 64'h3);
    chk("p3_err", 64'(err0), 64'h1);
    corrupt_g = -1;
    pulse0();
    chk("p3_restart_out", 64'(out0), 64'h0);
    chk("p3_restart_err", 64'(err0), 64'h0);
    wait0(ok);
    chk("p3b_done", 64'(ok), 64'h1);
    chk("p3b_out", 64'(out0), 64'h1);
    chk("p3b_err", 64'(err0), 64'h0);

    // Pass 4: bresp SLVERR on burst 3 plus rresp DECERR on one read beat
    bresp_bst = 3; rresp_g = 50;
    pulse0(); wait0(ok);
    chk("p4_done", 64'(ok), 64'h1);
    chk("p4_out", 64'(out0), 64'h3);
    chk("p4_err", 64'(err0), 64'h2);
    rresp_g = -1;

    // Single-beat 128-bit instance
    n0 = aw1_n; n1 = w1_n; n2 = w1_last;
    run1(ok);
    chk("d1_done", 64'(ok), 64'h1);
    chk("d1_out", 64'(out1), 64'h1);
    chk("d1_err", 64'(err1), 64'h0);
    chk("d1_aw_n", 64'(aw1_n - n0), 64'd1);
    chk("d1_w_n", 64'(w1_n - n1), 64'd1);
    chk("d1_wlast_n", 64'(w1_last - n2), 64'd1);
    chk("d1_awsize", 64'(awsize1), 64'h4);
    chk("d1_wdata", 64'(mem1), 64'h1000_0000);
    drop1 = 1'b1;
    run1(ok);
    chk("d1_nolast_done", 64'(ok), 64'h1);
    chk("d1_nolast_out", 64'(out1), 64'h3);
    chk("d1_nolast_err", 64'(err1), 64'h1);

    // Pass 5: error on burst 0, then reset in the middle of burst 1's data
    bresp_bst = 0;
    pulse0();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err0 == 16'd1 && if0.wvalid) begin ok = 1'b1; break; end
    end
    chk("p5_reach_wd", 64'(ok), 64'h1);
    @(negedge clk);
    chk("p5_mid_wvalid", 64'(if0.wvalid), 64'h1);
    chk("p5_pre_out", 64'(out0), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("p5_rst_awvalid", 64'(if0.awvalid), 64'h0);
    chk("p5_rst_wvalid", 64'(if0.wvalid), 64'h0);
    chk("p5_rst_bready", 64'(if0.bready), 64'h0);
    chk("p5_rst_arvalid", 64'(if0.arvalid), 64'h0);
    chk("p5_rst_rready", 64'(if0.rready), 64'h0);
    chk("p5_rst_out", 64'(out0), 64'h0);
    chk("p5_rst_err", 64'(err0), 64'h0);
    rst = 1'b0;
    bresp_bst = -1;
    aw_b = aw_log.size();
    pulse0(); wait0(ok);
    chk("p5b_done", 64'(ok), 64'h1);
    chk("p5b_out", 64'(out0), 64'h1);
    chk("p5b_err", 64'(err0), 64'h0);
    chk("p5b_aw_n", 64'(aw_log.size() - aw_b), 64'd8);
    chk("p5b_stable", 64'(stab_err), 64'h0);
    chk("p5b_no_overlap", 64'(ovl_err), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_noc_traffic_gen.md
Name: axi_noc_traffic_gen

Overview:
- Parametrised AXI4 master traffic generator/checker for NoC bring-up; successor to the single-shot NoC transaction tester.
- On start, writes N_TRANS INCR bursts of a deterministic pattern from BASE_ADDR, then reads them back and checks every beat.
- Reports done/error status and a saturating error count; one transaction outstanding at a time.

Parameters:
- DATA_W, 64, data width in bits (power of 2, 32..512)
- ADDR_W, 64, address width
- ID_W, 2, AXI ID width
- TXN_ID, 0, ID driven on awid/arid and expected on bid/rid
- BURST_LEN, 16, beats per burst (1..256); awlen = arlen = BURST_LEN-1
- N_TRANS, 8, bursts per pass (1..65535)
- BASE_ADDR, 0, byte address of first burst
- SEED, 32'h1000_0000, pattern seed

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level; begins a pass when in IDLE or DONE
- out  out  2  [0]=done, [1]=error (sticky for the pass)
- err_cnt  out  16  failing beats/responses this pass, saturates at 16'hFFFF
- awvalid/awready/awaddr[ADDR_W]/awlen[8]/awsize[3]/awburst[2]/awid[ID_W]  AXI AW
- awcache[4]/awprot[3]/awqos[4]/awregion[4]/awlock[1]/awuser[18]  out  constant sideband
- wvalid/wready/wdata[DATA_W]/wstrb[DATA_W/8]/wlast  AXI W
- bvalid/bready/bid[ID_W]/bresp[2]  AXI B
- arvalid/arready/araddr/arlen/arsize/arburst/arid + same constant sideband  AXI AR
- rvalid/rready/rdata[DATA_W]/rid[ID_W]/rresp[2]/rlast  AXI R

Behaviour:
- Reset: state IDLE; all valids, bready, rready, out, err_cnt = 0; counters 0. Reset mid-burst drops valids at the next edge (NoC is reset with the block).
- Constants: awsize = arsize = log2(DATA_W/8); burst INCR (2'b01); cache 4'b0011; prot, qos, region, lock, user = 0; wstrb all ones; id = TXN_ID.
- Burst t (0..N_TRANS-1) address = BASE_ADDR + t*BURST_LEN*DATA_W/8, ADDR_W wrap-around.
- Pattern: global beat g = t*BURST_LEN + beat; data = (SEED + g) zero-extended to DATA_W, 32-bit add modulo 2^32.
- FSM:
  - IDLE/DONE --start--> WA: clears out and err_cnt.
  - WA: awvalid=1, held until awready -> WD.
  - WD: wvalid=1, beat index advances on wready; wlast on beat BURST_LEN-1; final handshake -> WB.
  - WB: bready=1; on bvalid -> t++ and WA, or RA with t=0 after the last burst.
  - RA: arvalid=1 until arready -> RD.
  - RD: rready=1, each rvalid beat checked -> after rvalid&rlast, t++ and RA, or DONE.
  - DONE: out[0]=1; holds until start.
- Valid/payload never change while valid=1 and ready=0. AW and W are never concurrent.
- Errors: each of the following adds 1 to err_cnt and sets out[1]:
  - B: bresp!=0 or bid!=TXN_ID.
  - R, per beat: rdata!=pattern, rresp!=0, rid!=TXN_ID, or rlast!=(beat==BURST_LEN-1).
  - Several faults on one beat add 1, not several.
- A missing rlast does not hang RD; the burst ends after BURST_LEN beats.
- start while busy is ignored. Start held high in DONE restarts immediately (DONE lasts one cycle).
- out/err_cnt are registered; updated the cycle after the causing handshake.

Test Plan:
- Defaults, always-ready memory model: 8 AW at 0x0,0x80,...,0x380 with awlen=15, 128 W beats 0x10000000..0x1000007F, then 8 reads -> out=2'b01, err_cnt=0.
- Random ready/valid backpressure on all channels -> payload stable while stalled, same final result, no AW/W overlap.
- Memory corrupts rdata of global beat 37 -> err_cnt=1, out=2'b11; next start clears both before traffic.
- bresp=2'b10 on burst 3 plus rresp=2'b11 on one beat -> err_cnt=2.
- BURST_LEN=1, N_TRANS=1, DATA_W=128 -> awsize=4, wlast on the only beat, done after 1 write + 1 read; slave drops rlast -> err_cnt=1.
- rst asserted in WD mid-burst -> next cycle all valids 0, out=0; a fresh start runs a full clean pass.
